fifo_flops_core: RTL and testbench

Synchronous first-in/first-out buffer built from flip-flops, parameterized in depth and data width. It buffers words between a producer issuing `push` and a consumer issuing `pop`, reporting occupancy through `full` and `pndng` (data pending). It is the storage element exercised by the FIFO verification environment, which uses a driver, checker, scoreboard and agent, through the `fifo_if` interface.

---
 rtl/fifo_flops_core.sv | 104 ++++++++++
 tb/tb_fifo_flops_core.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_flops_core.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_flops_core
//  Purpose  : Synchronous first-word-fall-through FIFO built from flip-flops.
//             Buffers words between a producer (push) and a consumer (pop)
//             and reports occupancy through full / pndng.
//  Params   : depth - number of storage entries (>= 2, any integer)
//             bits  - data word width
//  Ports    : clk   - clock, all state changes on the rising edge
//             rst   - asynchronous active-low reset (synchronous release)
//             Din   - write data, sampled on a rising edge with push=1
//             push  - write request (one attempt per edge while high)
//             pop   - read request (consumer samples Dout in that cycle)
//             Dout  - oldest stored word, zero when empty
//             full  - occupancy == depth
//             pndng - occupancy >= 1
//  Options  : FIFO_FLOPS_OVERWRITE_EN - when defined, a push into a full FIFO
//             without pop overwrites the oldest entry; otherwise it is dropped.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_flops_core #(
    parameter int unsigned depth = 8,
    parameter int unsigned bits  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [bits-1:0] Din,
    input  logic            push,
    input  logic            pop,
    output logic [bits-1:0] Dout,
    output logic            full,
    output logic            pndng
);

    localparam int unsigned c_PTR_W = (depth > 1) ? $clog2(depth) : 1;
    localparam int unsigned c_CNT_W = $clog2(depth + 1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(depth - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(depth);

    logic [bits-1:0]    r_mem [depth];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_wr_en;
    logic w_rd_en;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] ptr);
        return (ptr == c_PTR_LAST) ? '0 : ptr + c_PTR_W'(1);
    endfunction

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_CNT_FULL);

`ifdef FIFO_FLOPS_OVERWRITE_EN
    // A push into a full FIFO always writes; without a pop it forces the
    // read pointer forward so the oldest word is discarded.
    assign w_wr_en = push;
    assign w_rd_en = (pop && !w_empty) || (push && w_full);
`else
    // A push into a full FIFO only lands when a pop frees a slot that edge.
    assign w_wr_en = push && (!w_full || pop);
    assign w_rd_en = pop && !w_empty;
`endif

    // Storage is intentionally not reset; Dout masks it while empty.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= Din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            end
            if (w_rd_en) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end
            // Simultaneous write and read (including overwrite) keep the count.
            if (w_wr_en && !w_rd_en) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_rd_en && !w_wr_en) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    // Flags and data decode purely from registered state: no path from
    // push/pop, and everything clears the moment rst asserts.
    assign full  = w_full;
    assign pndng = !w_empty;
    assign Dout  = w_empty ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_fifo_flops_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_flops_core
//  Purpose  : Directed self-checking bench for fifo_flops_core (depth 8,
//             16-bit words) with hand-computed expected values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_flops_core;

    localparam int unsigned c_DEPTH = 8;
    localparam int unsigned c_BITS  = 16;

    logic              clk;
    logic              rst;
    logic [c_BITS-1:0] Din;
    logic              push;
    logic              pop;
    logic [c_BITS-1:0] Dout;
    logic              full;
    logic              pndng;

    int n_cmp;
    int n_err;

    fifo_flops_core #(
        .depth (c_DEPTH),
        .bits  (c_BITS)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .Din   (Din),
        .push  (push),
        .pop   (pop),
        .Dout  (Dout),
        .full  (full),
        .pndng (pndng)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs, take one rising edge, and land 1 time unit after it.
    task automatic cyc(input logic p_push, input logic p_pop, input logic [c_BITS-1:0] p_din);
        push = p_push;
        pop  = p_pop;
        Din  = p_din;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        push  = 1'b1;
        pop   = 1'b0;
        Din   = 16'hAAAA;

        // ---------------- reset held with push active ----------------
        #1;
        chk("rst_full0",  {31'd0, full},  32'd0);
        chk("rst_pndng0", {31'd0, pndng}, 32'd0);
        chk("rst_dout0",  {16'd0, Dout},  32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_full",  {31'd0, full},  32'd0);
            chk("rst_pndng", {31'd0, pndng}, 32'd0);
            chk("rst_dout",  {16'd0, Dout},  32'd0);
        end
        rst = 1'b1;
        cyc(1'b1, 1'b0, 16'hAAAA);
        chk("first_push_pndng", {31'd0, pndng}, 32'd1);
        chk("first_push_dout",  {16'd0, Dout},  32'h0000AAAA);
        cyc(1'b0, 1'b1, 16'h0000);
        chk("first_pop_pndng", {31'd0, pndng}, 32'd0);
        chk("first_pop_dout",  {16'd0, Dout},  32'd0);

        // ---------------- fill and overflow ----------------
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 1'b0, 16'(i));
            chk("fill_full",  {31'd0, full},  (i == 8) ? 32'd1 : 32'd0);
            chk("fill_dout",  {16'd0, Dout},  32'd1);
        end
        cyc(1'b1, 1'b0, 16'h00FF);
        chk("ovf_full", {31'd0, full}, 32'd1);
`ifdef FIFO_FLOPS_OVERWRITE_EN
        chk("ovf_dout", {16'd0, Dout}, 32'd2);
`else
        chk("ovf_dout", {16'd0, Dout}, 32'd1);
`endif

        // ---------------- drain ----------------
        for (int i = 0; i < 8; i++) begin
`ifdef FIFO_FLOPS_OVERWRITE_EN
            chk("drain_dout", {16'd0, Dout}, (i < 7) ? 32'(i + 2) : 32'h00FF);
`else
            chk("drain_dout", {16'd0, Dout}, 32'(i + 1));
`endif
            cyc(1'b0, 1'b1, 16'h0000);
            chk("drain_full", {31'd0, full}, 32'd0);
        end
        chk("drain_pndng", {31'd0, pndng}, 32'd0);
        chk("drain_dout0", {16'd0, Dout},  32'd0);

        // ---------------- underflow ----------------
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 16'h0000);
            chk("udf_pndng", {31'd0, pndng}, 32'd0);
            chk("udf_dout",  {16'd0, Dout},  32'd0);
            chk("udf_full",  {31'd0, full},  32'd0);
        end
        cyc(1'b1, 1'b0, 16'h1234);
        chk("udf_push_dout",  {16'd0, Dout},  32'h00001234);
        chk("udf_push_pndng", {31'd0, pndng}, 32'd1);
        cyc(1'b0, 1'b1, 16'h0000);
        chk("udf_pop_pndng", {31'd0, pndng}, 32'd0);

        // ---------------- simultaneous traffic with 4 held ----------------
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 16'(16'h0010 + i));
        end
        for (int i = 0; i < 20; i++) begin
            chk("sim_dout", {16'd0, Dout}, 32'(16'h0010 + i));
            cyc(1'b1, 1'b1, 16'(16'h0014 + i));
            chk("sim_full",  {31'd0, full},  32'd0);
            chk("sim_pndng", {31'd0, pndng}, 32'd1);
        end
        // Exactly four words must remain: 0x24..0x27.
        for (int i = 0; i < 4; i++) begin
            chk("sim_tail_dout",  {16'd0, Dout},  32'(16'h0024 + i));
            chk("sim_tail_pndng", {31'd0, pndng}, 32'd1);
            cyc(1'b0, 1'b1, 16'h0000);
        end
        chk("sim_tail_empty", {31'd0, pndng}, 32'd0);

        // ---------------- push+pop while empty ----------------
        cyc(1'b1, 1'b1, 16'h0055);
        chk("emp_pp_pndng", {31'd0, pndng}, 32'd1);
        chk("emp_pp_dout",  {16'd0, Dout},  32'h00000055);
        cyc(1'b0, 1'b1, 16'h0000);
        chk("emp_pp_count1", {31'd0, pndng}, 32'd0);

        // ---------------- push+pop while full ----------------
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 16'(16'h0040 + i));
        end
        cyc(1'b1, 1'b1, 16'h0048);
        chk("full_pp_full", {31'd0, full}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("full_pp_dout", {16'd0, Dout}, 32'(16'h0041 + i));
            cyc(1'b0, 1'b1, 16'h0000);
        end
        chk("full_pp_empty", {31'd0, pndng}, 32'd0);

        // ---------------- asynchronous reset mid-stream ----------------
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 16'(16'h0031 + i));
        end
        push = 1'b0;
        chk("arst_pre_pndng", {31'd0, pndng}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_pndng", {31'd0, pndng}, 32'd0);
        chk("arst_dout",  {16'd0, Dout},  32'd0);
        chk("arst_full",  {31'd0, full},  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1'b0, 1'b1, 16'h0000);
        chk("arst_stale_pndng", {31'd0, pndng}, 32'd0);
        chk("arst_stale_dout",  {16'd0, Dout},  32'd0);
        cyc(1'b1, 1'b0, 16'h0077);
        chk("arst_new_dout", {16'd0, Dout}, 32'h00000077);
        cyc(1'b0, 1'b1, 16'h0000);
        chk("arst_new_empty", {31'd0, pndng}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
